sipo_rx: RTL and testbench
==========================

SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001: Parameter WIDTH, default 4; data word width in bits; legal range 2..16.
REQ-002: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003: reset  input  1  asynchronous, active-low reset.
REQ-004: si  input  1  serial data bit; words arrive LSB first.
REQ-005: en  input  1  bit qualifier; si and start are sampled only on edges where en=1.
REQ-006: start  input  1  marks the qualified bit as bit 0 of a new word.
REQ-007: po  output  WIDTH  last completed word.
REQ-008: po_valid  output  1  one-cycle pulse when po is updated.
REQ-009: busy  output  1  high while a word is partially received.
REQ-010: frame_err  output  1  one-cycle pulse when start arrives mid-word.
REQ-011: parity_err  output  1  one-cycle parity-failure flag, coincident with po_valid.

Function
REQ-012: States SHALL be IDLE, SHIFT and PAR; PAR exists only when the Configuration macro is defined.
REQ-013: IDLE: on en=1 and start=1, the block SHALL capture si as bit 0, set the bit count to 1 and enter SHIFT; qualified bits without start SHALL be discarded.
REQ-014: SHIFT: each en=1 with start=0 SHALL store si at bit position equal to the count, then increment the count.
REQ-015: en=0 SHALL hold all state; start with en=0 SHALL be ignored in every state.
REQ-016: Storing bit WIDTH-1 without parity SHALL return to IDLE, load po and pulse po_valid, both visible in the cycle after that edge.
REQ-017: po SHALL hold its value until the next completed word; partial words SHALL never alter po.
REQ-018: SHIFT or PAR with en=1 and start=1: frame_err SHALL pulse the next cycle; the partial word SHALL be discarded; the current bit SHALL become bit 0 of a new word (count=1, state SHIFT).
REQ-019: A start qualified on the edge directly after a word completes SHALL be accepted; back-to-back words need no idle cycle.
REQ-020: busy SHALL equal 1 exactly when the state is not IDLE.
REQ-021: po_valid, frame_err and parity_err SHALL each be at most one cycle wide per event.

Reset
REQ-022: reset=0 SHALL immediately force state IDLE, count 0, po=0, po_valid=0, busy=0, frame_err=0, parity_err=0, regardless of clk.
REQ-023: Reset mid-word SHALL discard the partial word with no po_valid; reception resumes on the first start after reset=1.

Configuration
REQ-024: Macro SIPO_RX_PARITY_EN, when defined, SHALL add state PAR after bit WIDTH-1; the next qualified bit is the parity bit.
REQ-025: With SIPO_RX_PARITY_EN: after the parity bit, po and po_valid SHALL update as in REQ-016; parity_err=1 with po_valid iff the XOR of data and parity bit is 1 (even parity).
REQ-026: Without SIPO_RX_PARITY_EN: no PAR state; parity_err SHALL be tied to 0.

Verification (WIDTH=4)
REQ-027: Reset, then start+bits 1,1,0,1 with en=1 continuously -> po=4'hB, po_valid high one cycle, busy low the same cycle.
REQ-028: Bits 0,1,0,1 with en=0 gaps of 1-3 cycles -> po=4'hA only after the 4th qualified bit; po unchanged during gaps.
REQ-029: Start+bits 1,0, then start+bits 1,1,0,0 -> frame_err one pulse, then po=4'h3 with one po_valid.
REQ-030: reset=0 asynchronously after 2 bits -> all outputs 0 without a clock edge; then word 4'h6 -> po=4'h6.
REQ-031: Words 4'h5 and 4'hC back-to-back, start on the next edge after completion -> two po_valid pulses, po=5 then C.
REQ-032: SIPO_RX_PARITY_EN: 4'h7 + parity 1 -> po=7, parity_err=0; 4'h7 + parity 0 -> po=7, parity_err=1 with po_valid.

Source files
------------

// File: rtl/sipo_rx_if.sv
// -----------------------------------------------------------------------------
// sipo_rx_if -- bus bundle for the serial-in / parallel-out receiver.
//
// Signals
//   si         serial data bit, words arrive LSB first
//   en         bit qualifier; si/start are only meaningful while en=1
//   start      marks the qualified bit as bit 0 of a new word
//   po         last completed word (WIDTH bits)
//   po_valid   one-cycle pulse when po is updated
//   busy       high while a word is partially received
//   frame_err  one-cycle pulse when start arrives mid-word
//   parity_err one-cycle parity-failure flag, coincident with po_valid
//
// Modports
//   master  drives the serial side, observes the parallel side (bench / source)
//   slave   the receiver itself
// -----------------------------------------------------------------------------
interface sipo_rx_if #(
  parameter int unsigned WIDTH = 4
);
  logic             si;
  logic             en;
  logic             start;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             busy;
  logic             frame_err;
  logic             parity_err;

  modport master (
    output si,
    output en,
    output start,
    input  po,
    input  po_valid,
    input  busy,
    input  frame_err,
    input  parity_err
  );

  modport slave (
    input  si,
    input  en,
    input  start,
    output po,
    output po_valid,
    output busy,
    output frame_err,
    output parity_err
  );
endinterface

// File: rtl/sipo_rx.sv
// -----------------------------------------------------------------------------
// sipo_rx -- serial-in / parallel-out word receiver.
//
// Collects WIDTH qualified serial bits (LSB first) following a start marker and
// presents the completed word on po with a one-cycle po_valid pulse. A start
// seen mid-word raises frame_err and restarts reception with the current bit as
// bit 0. po only changes when a whole word has been received.
//
// Optional feature: define SIPO_RX_PARITY_EN to append one even-parity bit after
// the data bits (extra PAR state); parity_err then pulses with po_valid when
// XOR(data, parity) is 1. Without the macro parity_err is tied low.
//
// Ports
//   i_clk    sole clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      sipo_rx_if.slave (si, en, start in; po, po_valid, busy,
//            frame_err, parity_err out)
// -----------------------------------------------------------------------------
module sipo_rx #(
  parameter int unsigned WIDTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  sipo_rx_if.slave    bus
);

  // Count only ever holds 0..WIDTH-1, so the index width is enough.
  localparam int unsigned    CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

`ifdef SIPO_RX_PARITY_EN
  typedef enum logic [1:0] {StIdle = 2'd0, StShift = 2'd1, StPar = 2'd2} state_e;
`else
  typedef enum logic [1:0] {StIdle = 2'd0, StShift = 2'd1} state_e;
`endif

  state_e           r_state,     w_state_nxt;
  logic [CntW-1:0]  r_cnt,       w_cnt_nxt;
  logic [WIDTH-1:0] r_shreg,     w_shreg_nxt;
  logic [WIDTH-1:0] r_po,        w_po_nxt;
  logic             r_po_valid,  w_po_valid_nxt;
  logic             r_frame_err, w_frame_err_nxt;
`ifdef SIPO_RX_PARITY_EN
  logic             r_parity_err, w_parity_err_nxt;
`endif

  // The current bit as bit 0 of a fresh word.
  logic [WIDTH-1:0] w_first_word;
  assign w_first_word = {{(WIDTH-1){1'b0}}, bus.si};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_shreg      <= '0;
      r_po         <= '0;
      r_po_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shreg      <= w_shreg_nxt;
      r_po         <= w_po_nxt;
      r_po_valid   <= w_po_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
`ifdef SIPO_RX_PARITY_EN
      r_parity_err <= w_parity_err_nxt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Pulses default low so each event is one cycle wide; en=0
  // leaves every register unchanged.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_shreg_nxt      = r_shreg;
    w_po_nxt         = r_po;
    w_po_valid_nxt   = 1'b0;
    w_frame_err_nxt  = 1'b0;
`ifdef SIPO_RX_PARITY_EN
    w_parity_err_nxt = 1'b0;
`endif

    if (bus.en) begin
      unique case (r_state)
        StIdle: begin
          // Qualified bits without start are dropped here.
          if (bus.start) begin
            w_shreg_nxt = w_first_word;
            w_cnt_nxt   = CntOne;
            w_state_nxt = StShift;
          end
        end

        StShift: begin
          if (bus.start) begin
            // Restart: partial word is discarded, this bit begins a new one.
            w_frame_err_nxt = 1'b1;
            w_shreg_nxt     = w_first_word;
            w_cnt_nxt       = CntOne;
          end else begin
            for (int unsigned b = 0; b < WIDTH; b++) begin
              if (r_cnt == CntW'(b)) begin
                w_shreg_nxt[b] = bus.si;
              end
            end
            if (r_cnt == CntLast) begin
`ifdef SIPO_RX_PARITY_EN
              w_state_nxt = StPar;
`else
              w_po_nxt       = w_shreg_nxt;
              w_po_valid_nxt = 1'b1;
              w_cnt_nxt      = '0;
              w_state_nxt    = StIdle;
`endif
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end

`ifdef SIPO_RX_PARITY_EN
        StPar: begin
          if (bus.start) begin
            w_frame_err_nxt = 1'b1;
            w_shreg_nxt     = w_first_word;
            w_cnt_nxt       = CntOne;
            w_state_nxt     = StShift;
          end else begin
            // Even parity: data plus parity bit must XOR to 0.
            w_po_nxt         = r_shreg;
            w_po_valid_nxt   = 1'b1;
            w_parity_err_nxt = ^{r_shreg, bus.si};
            w_cnt_nxt        = '0;
            w_state_nxt      = StIdle;
          end
        end
`endif

        default: begin
          w_cnt_nxt   = '0;
          w_state_nxt = StIdle;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.po        = r_po;
  assign bus.po_valid  = r_po_valid;
  assign bus.frame_err = r_frame_err;
  // Derived straight from state so reset clears it without a clock edge.
  assign bus.busy      = (r_state != StIdle);
`ifdef SIPO_RX_PARITY_EN
  assign bus.parity_err = r_parity_err;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx.sv
// -----------------------------------------------------------------------------
// tb_sipo_rx -- self-checking bench for sipo_rx (WIDTH=4).
// Table of {en, start, si -> po, po_valid, busy, frame_err} rows applied one per
// clock, plus hand-written sequences for reset and the parity option
// (SIPO_RX_PARITY_EN).
// -----------------------------------------------------------------------------
module tb_sipo_rx;

  localparam int unsigned WIDTH = 4;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  sipo_rx_if #(.WIDTH(WIDTH)) u_bus ();

  sipo_rx #(.WIDTH(WIDTH)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (u_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       start;
    logic       si;
    logic [3:0] po;
    logic       valid;
    logic       busy;
    logic       ferr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic start, input logic si,
                     input logic [3:0] po, input logic valid, input logic busy,
                     input logic ferr);
    vec_t v;
    v.en = en; v.start = start; v.si = si;
    v.po = po; v.valid = valid; v.busy = busy; v.ferr = ferr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one set of inputs, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic en, input logic start, input logic si);
    u_bus.en    = en;
    u_bus.start = start;
    u_bus.si    = si;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_po"},    16'(u_bus.po),         16'h0);
    check({tag, "_valid"}, 16'(u_bus.po_valid),   16'h0);
    check({tag, "_busy"},  16'(u_bus.busy),       16'h0);
    check({tag, "_ferr"},  16'(u_bus.frame_err),  16'h0);
    check({tag, "_perr"},  16'(u_bus.parity_err), 16'h0);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    u_bus.en    = 1'b0;
    u_bus.start = 1'b0;
    u_bus.si    = 1'b0;
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

`ifndef SIPO_RX_PARITY_EN
    // 4'hB: bits 1,1,0,1 with en held high
    add(1, 1, 1, 4'h0, 0, 1, 0);
    add(1, 0, 1, 4'h0, 0, 1, 0);
    add(1, 0, 0, 4'h0, 0, 1, 0);
    add(1, 0, 1, 4'hB, 1, 0, 0);
    add(0, 0, 0, 4'hB, 0, 0, 0);
    // Qualified bit without start in idle is dropped
    add(1, 0, 1, 4'hB, 0, 0, 0);
    // 4'hA: bits 0,1,0,1 with en gaps; start while en=0 is ignored
    add(1, 1, 0, 4'hB, 0, 1, 0);
    add(0, 0, 0, 4'hB, 0, 1, 0);
    add(0, 1, 1, 4'hB, 0, 1, 0);
    add(1, 0, 1, 4'hB, 0, 1, 0);
    add(0, 0, 0, 4'hB, 0, 1, 0);
    add(0, 0, 1, 4'hB, 0, 1, 0);
    add(0, 1, 0, 4'hB, 0, 1, 0);
    add(1, 0, 0, 4'hB, 0, 1, 0);
    add(0, 0, 0, 4'hB, 0, 1, 0);
    add(0, 0, 0, 4'hB, 0, 1, 0);
    add(1, 0, 1, 4'hA, 1, 0, 0);
    add(0, 0, 0, 4'hA, 0, 0, 0);
    // Start+1,0 then start+1,1,0,0 -> one frame_err, then 4'h3
    add(1, 1, 1, 4'hA, 0, 1, 0);
    add(1, 0, 0, 4'hA, 0, 1, 0);
    add(1, 1, 1, 4'hA, 0, 1, 1);
    add(1, 0, 1, 4'hA, 0, 1, 0);
    add(1, 0, 0, 4'hA, 0, 1, 0);
    add(1, 0, 0, 4'h3, 1, 0, 0);
    add(0, 0, 0, 4'h3, 0, 0, 0);
    // 4'h5 then 4'hC back to back
    add(1, 1, 1, 4'h3, 0, 1, 0);
    add(1, 0, 0, 4'h3, 0, 1, 0);
    add(1, 0, 1, 4'h3, 0, 1, 0);
    add(1, 0, 0, 4'h5, 1, 0, 0);
    add(1, 1, 0, 4'h5, 0, 1, 0);
    add(1, 0, 0, 4'h5, 0, 1, 0);
    add(1, 0, 1, 4'h5, 0, 1, 0);
    add(1, 0, 1, 4'hC, 1, 0, 0);
    add(0, 0, 0, 4'hC, 0, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].start, vecs[i].si);
      check($sformatf("row%0d_po", i),    16'(u_bus.po),         16'(vecs[i].po));
      check($sformatf("row%0d_valid", i), 16'(u_bus.po_valid),   16'(vecs[i].valid));
      check($sformatf("row%0d_busy", i),  16'(u_bus.busy),       16'(vecs[i].busy));
      check($sformatf("row%0d_ferr", i),  16'(u_bus.frame_err),  16'(vecs[i].ferr));
      check($sformatf("row%0d_perr", i),  16'(u_bus.parity_err), 16'h0);
    end
`else
    // 4'h7 with parity 1: ones count even, no error
    step(1, 1, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    step(1, 0, 0);
    check("par_wait_busy",  16'(u_bus.busy),     16'h1);
    check("par_wait_valid", 16'(u_bus.po_valid), 16'h0);
    check("par_wait_po",    16'(u_bus.po),       16'h0);
    step(1, 0, 1);
    check("par_ok_po",    16'(u_bus.po),         16'h7);
    check("par_ok_valid", 16'(u_bus.po_valid),   16'h1);
    check("par_ok_perr",  16'(u_bus.parity_err), 16'h0);
    check("par_ok_busy",  16'(u_bus.busy),       16'h0);
    // 4'h7 with parity 0: odd ones count, error with po_valid
    step(1, 1, 1);
    step(1, 0, 1);
    step(1, 0, 1);
    step(1, 0, 0);
    step(1, 0, 0);
    check("par_bad_po",    16'(u_bus.po),         16'h7);
    check("par_bad_valid", 16'(u_bus.po_valid),   16'h1);
    check("par_bad_perr",  16'(u_bus.parity_err), 16'h1);
    step(0, 0, 0);
    check("par_bad_perr_clr",  16'(u_bus.parity_err), 16'h0);
    check("par_bad_valid_clr", 16'(u_bus.po_valid),   16'h0);
    // Start during the parity slot restarts the word
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 1, 1);
    check("par_restart_ferr",  16'(u_bus.frame_err), 16'h1);
    check("par_restart_valid", 16'(u_bus.po_valid),  16'h0);
    check("par_restart_busy",  16'(u_bus.busy),      16'h1);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 1);
    check("par_restart_po",   16'(u_bus.po),         16'h1);
    check("par_restart_perr", 16'(u_bus.parity_err), 16'h0);
`endif

    // Asynchronous reset after two bits of a word, away from any clock edge
    step(1, 1, 0);
    step(1, 0, 1);
    check("pre_rst_busy", 16'(u_bus.busy), 16'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    #2;
    rst_n = 1'b1;
    step(1, 0, 1);
    check("post_rst_idle_busy", 16'(u_bus.busy), 16'h0);
    // 4'h6: bits 0,1,1,0
    step(1, 1, 0);
    step(1, 0, 1);
    step(1, 0, 1);
    step(1, 0, 0);
`ifdef SIPO_RX_PARITY_EN
    check("w6_wait_valid", 16'(u_bus.po_valid), 16'h0);
    step(1, 0, 0);
`endif
    check("w6_po",    16'(u_bus.po),         16'h6);
    check("w6_valid", 16'(u_bus.po_valid),   16'h1);
    check("w6_busy",  16'(u_bus.busy),       16'h0);
    check("w6_perr",  16'(u_bus.parity_err), 16'h0);
    step(0, 0, 0);
    check("w6_valid_clr", 16'(u_bus.po_valid), 16'h0);
    check("w6_po_hold",   16'(u_bus.po),       16'h6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
